alu_mem_sequencer: RTL
======================

ALU_MEM_SEQUENCER -- requirements
Module: alu_mem_sequencer

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 start  input  1  command request; sampled on clk when accepted (IDLE or DONE state).
REQ-004 cmd_opcode  input  3  ALU opcode for the command (000 add … 111 shr).
REQ-005 cmd_src_a / cmd_src_b / cmd_dst  input  4 each  memory addresses: operand1 source, operand2 source, result destination.
REQ-006 busy  output  1  high in states RD_A, RD_B, LD_B, EXEC, WRITE.
REQ-007 done  output  1  one-cycle pulse in DONE state.
REQ-008 result  output  8  last computed ALU result, held until next EXEC.
REQ-009 mem_addr  output  4 / mem_wdata  output  16 / mem_we  output  1  drive result memory (registered read, 1-cycle latency).
REQ-010 mem_rdata  input  16  memory read data.
REQ-011 alu_opcode  output  3 / alu_op1, alu_op2  output  8  drive combinational ALU; alu_result  input  8.

Function
REQ-012 States: IDLE, RD_A, RD_B, LD_B, EXEC, WRITE, DONE; exactly one active per cycle.
REQ-013 IDLE/DONE with start=1 SHALL capture cmd_* into internal registers and go to RD_A; without start, IDLE holds and DONE goes to IDLE.
REQ-014 RD_A: mem_addr=src_a, -> RD_B.
REQ-015 RD_B: mem_addr=src_b; at edge op1_reg <= mem_rdata[7:0]; -> LD_B.
REQ-016 LD_B: at edge op2_reg <= mem_rdata[7:0]; -> EXEC; mem_rdata[15:8] ignored.
REQ-017 EXEC: alu_op1=op1_reg, alu_op2=op2_reg, alu_opcode=captured opcode; at edge result <= alu_result; -> WRITE.
REQ-018 WRITE: mem_we=1, mem_addr=dst, mem_wdata={8'h00,result}; -> DONE.
REQ-019 mem_we SHALL be 1 only in WRITE; mem_addr=0 in IDLE/DONE.
REQ-020 Latency: start accepted at edge N -> write committed at edge N+5, done high in cycle after edge N+5.
REQ-021 Back-to-back: start during DONE SHALL be accepted (DONE -> RD_A); throughput one command per 6 cycles.
REQ-022 start while busy SHALL be ignored; captured command unaffected by cmd_* changes while busy.
REQ-023 Every opcode, including 010 (not, unary), SHALL follow the full read-A/read-B sequence.
REQ-024 dst equal to src_a or src_b SHALL be legal; reads complete before write.
REQ-025 alu_op1/alu_op2/alu_opcode SHALL reflect held registers in all states.

Reset
REQ-026 rst=1 at edge SHALL force IDLE; busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0, result=0, alu_opcode=0, alu_op1=0, alu_op2=0.
REQ-027 Reset mid-command SHALL abandon it; no memory write issued after the reset edge; start during rst ignored.

Configuration
REQ-028 Macro ALU_SEQ_FLAGS_EN: when defined, outputs flag_zero (1) and flag_carry (1) exist, updated at EXEC edge, reset to 0.
REQ-029 flag_zero = (alu_result==0); flag_carry = bit 8 of 9-bit op1+op2 for opcode 000, (op1<op2) for 001, 0 otherwise.
REQ-030 Without ALU_SEQ_FLAGS_EN: flag ports and logic absent; all other behaviour identical.

Verification
REQ-031 mem[0]=0x0010, mem[1]=0x0020; start ADD src_a=0 src_b=1 dst=3 -> mem[3]=0x0030, result=0x30, done 6 cycles after start.
REQ-032 Then SUB src_a=3 src_b=2 (mem[2]=0x0030) dst=4 -> mem[4]=0x0000; with flags, flag_zero=1, flag_carry=0.
REQ-033 SUB 0x10-0x20 -> result=0xF0; with flags, flag_carry=1; two commands, second start asserted in DONE -> second done exactly 6 cycles after first.
REQ-034 rst asserted in WRITE cycle -> mem_we=0 after edge, dst location unchanged, busy=0, done never pulses.
REQ-035 start pulsed while busy with different cmd_* -> ignored; original command's result written, only one done pulse.

Source files
------------

// File: rtl/alu_mem_sequencer.sv
// alu_mem_sequencer
//
// Runs one memory-to-memory ALU command at a time. An accepted command reads
// operand A and operand B from a registered-read memory (1-cycle latency),
// drives an external combinational ALU, captures its result and writes it
// back to the destination address. One command takes 6 cycles, start to start.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   start, cmd_opcode,       command request and fields; sampled only in
//   cmd_src_a/b, cmd_dst     IDLE or DONE
//   busy, done               busy in RD_A..WRITE, one-cycle done pulse in DONE
//   result                   last ALU result, held until the next EXEC
//   mem_addr/wdata/we,       result memory port
//   mem_rdata
//   alu_opcode/op1/op2,      external combinational ALU
//   alu_result
//
// Build option
//   ALU_SEQ_FLAGS_EN         adds flag_zero / flag_carry outputs, captured at EXEC

module alu_mem_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  cmd_opcode,
    input  logic [3:0]  cmd_src_a,
    input  logic [3:0]  cmd_src_b,
    input  logic [3:0]  cmd_dst,
    output logic        busy,
    output logic        done,
    output logic [7:0]  result,
    output logic [3:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    output logic [2:0]  alu_opcode,
    output logic [7:0]  alu_op1,
    output logic [7:0]  alu_op2,
    input  logic [7:0]  alu_result
`ifdef ALU_SEQ_FLAGS_EN
    ,
    output logic        flag_zero,
    output logic        flag_carry
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StRdA,
        StRdB,
        StLdB,
        StExec,
        StWrite,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  opcode_q, opcode_d;
    logic [3:0]  src_a_q, src_a_d;
    logic [3:0]  src_b_q, src_b_d;
    logic [3:0]  dst_q, dst_d;
    logic [7:0]  op1_q, op1_d;
    logic [7:0]  op2_q, op2_d;
    logic [7:0]  result_q, result_d;

    // Next state and captured registers
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        src_a_d  = src_a_q;
        src_b_d  = src_b_q;
        dst_d    = dst_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        result_d = result_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    opcode_d = cmd_opcode;
                    src_a_d  = cmd_src_a;
                    src_b_d  = cmd_src_b;
                    dst_d    = cmd_dst;
                    state_d  = StRdA;
                end else begin
                    state_d  = StIdle;
                end
            end
            StRdA:   state_d = StRdB;
            StRdB: begin
                // Read data for src_a arrives one cycle after its address
                op1_d   = mem_rdata[7:0];
                state_d = StLdB;
            end
            StLdB: begin
                op2_d   = mem_rdata[7:0];
                state_d = StExec;
            end
            StExec: begin
                result_d = alu_result;
                state_d  = StWrite;
            end
            StWrite: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            opcode_q <= 3'd0;
            src_a_q  <= 4'd0;
            src_b_q  <= 4'd0;
            dst_q    <= 4'd0;
            op1_q    <= 8'd0;
            op2_q    <= 8'd0;
            result_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            src_a_q  <= src_a_d;
            src_b_q  <= src_b_d;
            dst_q    <= dst_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            result_q <= result_d;
        end
    end

    // Outputs
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_addr  = 4'd0;
        mem_wdata = 16'd0;
        mem_we    = 1'b0;

        unique case (state_q)
            StRdA: begin
                busy     = 1'b1;
                mem_addr = src_a_q;
            end
            StRdB: begin
                busy     = 1'b1;
                mem_addr = src_b_q;
            end
            StLdB:  busy = 1'b1;
            StExec: busy = 1'b1;
            StWrite: begin
                busy      = 1'b1;
                mem_addr  = dst_q;
                mem_wdata = {8'h00, result_q};
                // A reset arriving in this cycle must cancel the write at its edge
                mem_we    = ~rst;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    assign result     = result_q;
    assign alu_opcode = opcode_q;
    assign alu_op1    = op1_q;
    assign alu_op2    = op2_q;

`ifdef ALU_SEQ_FLAGS_EN
    logic       flag_zero_q, flag_zero_d;
    logic       flag_carry_q, flag_carry_d;
    logic [8:0] sum9;

    always_comb begin
        flag_zero_d  = flag_zero_q;
        flag_carry_d = flag_carry_q;
        sum9         = {1'b0, op1_q} + {1'b0, op2_q};
        if (state_q == StExec) begin
            flag_zero_d = (alu_result == 8'd0);
            unique case (opcode_q)
                3'b000:  flag_carry_d = sum9[8];
                3'b001:  flag_carry_d = (op1_q < op2_q); // borrow
                default: flag_carry_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_zero_q  <= 1'b0;
            flag_carry_q <= 1'b0;
        end else begin
            flag_zero_q  <= flag_zero_d;
            flag_carry_q <= flag_carry_d;
        end
    end

    assign flag_zero  = flag_zero_q;
    assign flag_carry = flag_carry_q;
`endif

endmodule
